rgb_csc_pipe: RTL and testbench
===============================

# rgb_csc_pipe

Parametrised, pipelined RGB colour-space converter; successor to the fixed 8-bit single-mode RGB converter. Accepts one pixel per cycle over a valid/ready stream and produces grayscale, YCbCr (BT.601, full range) or bypass RGB. Tracks pixel position within a frame and flags the last pixel. Sits between the pixel source (memory/file reader) and the result sink/writer.

## Interface
- PIX_W, 8: bits per colour component (6..12)
- FRAME_PIX, 250000: pixels per frame (500×500); sets the pixel counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mode  in  2  0 = grayscale, 1 = YCbCr, 2 = bypass, 3 = reserved (treated as bypass)
- in_valid  in  1  input pixel valid
- in_ready  out  1  converter can accept a pixel
- r, g, b  in  PIX_W each  input components
- out_valid  out  1  output pixel valid
- out_ready  in  1  sink accepts output
- out_data  out  3*PIX_W  {c0,c1,c2}: gray {Y,Y,Y}; YCbCr {Y,Cb,Cr}; bypass {R,G,B}
- out_last  out  1  qualifies the last pixel of a frame
- pix_cnt  out  clog2(FRAME_PIX)  index of the next input pixel to be accepted

## Operation
- Transfer: a pixel is accepted when in_valid && in_ready; an output completes when out_valid && out_ready.
- Coefficients: Q8 fixed point. Y = (77R + 150G + 29B + 128) >>> 8; Cb = ((−43R − 85G + 128B + 128) >>> 8) + OFS; Cr = ((128R − 107G − 21B + 128) >>> 8) + OFS; OFS = 2^(PIX_W−1).
- Arithmetic: signed, width PIX_W+10; arithmetic shift (floor); final result clamped to [0, 2^PIX_W − 1].
- Mode is sampled once per frame, when a pixel is accepted with pix_cnt == 0, and held in a register for the remaining pixels of that frame. A mode change mid-frame takes effect at the next frame.
- pix_cnt increments on each accepted pixel and wraps from FRAME_PIX−1 to 0. The pixel accepted at FRAME_PIX−1 carries a last tag down the pipeline to out_last.
- Mode and last tag travel with the data through every stage.

## Timing
- Three stages: S1 products, S2 sums + rounding, S3 shift/offset/clamp into output register.
- Latency: 3 cycles from acceptance to out_valid with out_ready held high; throughput 1 pixel/cycle.
- Backpressure: global enable en = !out_valid || out_ready; all stages advance only when en. in_ready = en (combinational from out_ready and out_valid). Bubbles are not compressed.
- While stalled, out_data, out_last and out_valid are held stable.
- Reset (any time, including mid-frame): all stage valids = 0, out_valid = 0, out_data = 0, out_last = 0, pix_cnt = 0, mode register = 0. In-flight pixels are discarded. in_ready = 1 while reset is held.
- Simultaneous events: acceptance at pix_cnt == FRAME_PIX−1 together with a stall cannot occur, because acceptance requires en.

## Structure
- Shared package rgb_csc_pkg: mode encodings (MODE_GRAY, MODE_YCC, MODE_BYP), the nine Q8 coefficients, and the rounding constant 128.
- One sub-module: rgb_csc_mac. Computes one dot product (3 signed products, sum, round, shift, offset, clamp) in S1–S3 with enable. It is instantiated three times; the top holds the handshake, counter, mode and last pipelines, and the output mux.

## Test plan
- Reset/idle: rst_n low, then high with out_ready = 1 → out_valid = 0, out_data = 0, pix_cnt = 0, in_ready = 1.
- Grayscale, PIX_W = 8: feed (255,255,255) then (0,0,0) back-to-back → out_data 0xFFFFFF then 0x000000, exactly 3 cycles after each acceptance.
- YCbCr clamp: pure red (255,0,0) in mode 1 → {Y,Cb,Cr} = {77, 85, 255}. Cr is clamped from 256. White → {255,128,128}.
- Backpressure: stream 10 pixels with out_ready toggling 1-0-0-1 → no loss or duplication; outputs in order; out_data stable while out_valid && !out_ready.
- Frame wrap with FRAME_PIX = 4: switch mode from 0 to 2 after the second pixel → first 4 outputs are gray with out_last on the 4th, next frame is bypass; pix_cnt sequence 0,1,2,3,0.
- Mid-stream reset: assert rst_n low with 3 pixels in flight → no outputs emerge after reset; pix_cnt = 0; next frame restarts cleanly.

Source files
------------

// File: rtl/rgb_csc_pkg.sv
// Shared encodings and Q8 coefficients for the RGB colour-space converter.
package rgb_csc_pkg;

    typedef enum logic [1:0] {
        MODE_GRAY = 2'd0,
        MODE_YCC  = 2'd1,
        MODE_BYP  = 2'd2,
        MODE_RSV  = 2'd3
    } mode_e;

    localparam int unsigned FRAC_BITS = 8;
    localparam int          RND       = 128;

    // BT.601 full-range coefficients in Q8
    localparam int COEF_YR  = 77;
    localparam int COEF_YG  = 150;
    localparam int COEF_YB  = 29;
    localparam int COEF_CBR = -43;
    localparam int COEF_CBG = -85;
    localparam int COEF_CBB = 128;
    localparam int COEF_CRR = 128;
    localparam int COEF_CRG = -107;
    localparam int COEF_CRB = -21;

endpackage

// File: rtl/rgb_csc_mac.sv
// One pipelined dot product: products (S1), rounded sum (S2), then
// shift/offset/clamp presented combinationally for the caller's S3 register.
module rgb_csc_mac
    import rgb_csc_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int          K0    = 0,
    parameter int          K1    = 0,
    parameter int          K2    = 0,
    parameter int unsigned OFS   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PIX_W-1:0] x0,
    input  logic [PIX_W-1:0] x1,
    input  logic [PIX_W-1:0] x2,
    output logic [PIX_W-1:0] res_c
);

    localparam int unsigned AW = PIX_W + 10;

    localparam logic signed [AW-1:0] C0    = AW'(K0);
    localparam logic signed [AW-1:0] C1    = AW'(K1);
    localparam logic signed [AW-1:0] C2    = AW'(K2);
    localparam logic signed [AW-1:0] RND_S = AW'(RND);
    localparam logic signed [AW-1:0] OFS_S = AW'(OFS);
    localparam logic signed [AW-1:0] MAX_S = AW'(2 ** PIX_W - 1);

    logic signed [AW-1:0] sx0, sx1, sx2;
    logic signed [AW-1:0] p0, p1, p2;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] shr_c;
    logic signed [AW-1:0] ofs_c;

    // Components are unsigned; zero-extend before signed multiply
    assign sx0 = signed'(AW'(x0));
    assign sx1 = signed'(AW'(x1));
    assign sx2 = signed'(AW'(x2));

    // S1: three signed products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0 <= '0;
            p1 <= '0;
            p2 <= '0;
        end else if (en) begin
            p0 <= sx0 * C0;
            p1 <= sx1 * C1;
            p2 <= sx2 * C2;
        end
    end

    // S2: sum plus rounding constant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (en) begin
            sum <= p0 + p1 + p2 + RND_S;
        end
    end

    // S3 combinational part: floor shift, offset, clamp to the pixel range
    always_comb begin
        shr_c = sum >>> FRAC_BITS;
        ofs_c = shr_c + OFS_S;
        res_c = ofs_c[PIX_W-1:0];
        if (ofs_c[AW-1]) begin
            res_c = '0;
        end else if (ofs_c > MAX_S) begin
            res_c = '1;
        end
    end

endmodule

// File: rtl/rgb_csc_pipe.sv
// Three-stage RGB converter: gray / YCbCr / bypass with per-frame mode
// latch, pixel counter, last-pixel tag and global-enable backpressure.
module rgb_csc_pipe
    import rgb_csc_pkg::*;
#(
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned FRAME_PIX = 250000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PIX_W-1:0]             r,
    input  logic [PIX_W-1:0]             g,
    input  logic [PIX_W-1:0]             b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3*PIX_W-1:0]           out_data,
    output logic                         out_last,
    output logic [$clog2(FRAME_PIX)-1:0] pix_cnt
);

    localparam int unsigned CNT_W = $clog2(FRAME_PIX);
    localparam int unsigned DW    = 3 * PIX_W;
    localparam int unsigned OFS   = 2 ** (PIX_W - 1);

    logic          en_c, acc_c, first_c, last_c;
    mode_e         mode_q, cur_mode_c;
    logic          v1, v2, l1, l2;
    mode_e         m1, m2;
    logic [DW-1:0] rgb1, rgb2;
    logic [PIX_W-1:0] y_c, cb_c, cr_c;
    logic [DW-1:0] mux_c;

    // Whole pipeline advances together unless the output is blocked
    assign en_c       = !out_valid || out_ready;
    assign in_ready   = en_c;
    assign acc_c      = in_valid && en_c;
    assign first_c    = (pix_cnt == '0);
    assign last_c     = (pix_cnt == CNT_W'(FRAME_PIX - 1));
    assign cur_mode_c = first_c ? mode_e'(mode) : mode_q;

    // Pixel counter and per-frame mode latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            mode_q  <= MODE_GRAY;
        end else if (acc_c) begin
            pix_cnt <= last_c ? '0 : pix_cnt + CNT_W'(1);
            if (first_c) begin
                mode_q <= mode_e'(mode);
            end
        end
    end

    // Side-band pipeline: valid, mode, last tag and raw pixel for bypass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            l1   <= 1'b0;
            l2   <= 1'b0;
            m1   <= MODE_GRAY;
            m2   <= MODE_GRAY;
            rgb1 <= '0;
            rgb2 <= '0;
        end else if (en_c) begin
            v1   <= acc_c;
            l1   <= acc_c && last_c;
            m1   <= cur_mode_c;
            rgb1 <= {r, g, b};
            v2   <= v1;
            l2   <= l1;
            m2   <= m1;
            rgb2 <= rgb1;
        end
    end

    rgb_csc_mac #(.PIX_W(PIX_W), .K0(COEF_YR), .K1(COEF_YG), .K2(COEF_YB), .OFS(0)) u_mac_y (
        .clk(clk), .rst_n(rst_n), .en(en_c), .x0(r), .x1(g), .x2(b), .res_c(y_c)
    );

    rgb_csc_mac #(.PIX_W(PIX_W), .K0(COEF_CBR), .K1(COEF_CBG), .K2(COEF_CBB), .OFS(OFS)) u_mac_cb (
        .clk(clk), .rst_n(rst_n), .en(en_c), .x0(r), .x1(g), .x2(b), .res_c(cb_c)
    );

    rgb_csc_mac #(.PIX_W(PIX_W), .K0(COEF_CRR), .K1(COEF_CRG), .K2(COEF_CRB), .OFS(OFS)) u_mac_cr (
        .clk(clk), .rst_n(rst_n), .en(en_c), .x0(r), .x1(g), .x2(b), .res_c(cr_c)
    );

    // Output selection by the mode that travelled with the pixel
    always_comb begin
        mux_c = rgb2;
        case (m2)
            MODE_GRAY: mux_c = {y_c, y_c, y_c};
            MODE_YCC:  mux_c = {y_c, cb_c, cr_c};
            default:   mux_c = rgb2;
        endcase
    end

    // S3 output register; held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (en_c) begin
            out_valid <= v2;
            out_last  <= l2;
            if (v2) begin
                out_data <= mux_c;
            end
        end
    end

endmodule

// File: tb/tb_rgb_csc_pipe.sv
// Directed bench for rgb_csc_pipe (PIX_W = 8, FRAME_PIX = 4).
module tb_rgb_csc_pipe;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned FRAME_PIX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_data;
    logic        out_last;
    logic [1:0]  pix_cnt;

    rgb_csc_pipe #(.PIX_W(PIX_W), .FRAME_PIX(FRAME_PIX)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .r(r), .g(g), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .pix_cnt(pix_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [7:0]  r, g, b;
        logic [1:0]  mode;
        logic [23:0] data;
        logic        last;
    } vec_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;
    bit   lat_chk = 1'b0;
    bit   bp_on = 1'b0;

    vec_t tbl[16];
    vec_t wrap[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Offer one pixel and hold it until accepted; pix_cnt checked at acceptance
    task automatic send(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                        input logic [1:0] mm, input int cnt);
        bit done = 1'b0;
        r = rr; g = gg; b = bb; mode = mm; in_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                check("pix_cnt", 32'(pix_cnt), 32'(cnt));
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_run++; n_fail++;
            $display("FAIL send_timeout: got no acceptance, expected in_ready within 64 cycles");
        end
    endtask

    // Wait for all expected outputs to be consumed
    task automatic drain();
        int i = 0;
        while (exp_q.size() != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d outputs missing, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sink ready pattern 1-0-0-1 while backpressure is enabled
    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        forever begin
            @(posedge clk); #1;
            if (bp_on) begin
                out_ready = pat[k];
                k = (k + 1) % 4;
            end else begin
                out_ready = 1'b1;
                k = 0;
            end
        end
    end

    // Output monitor: ordering, last tag, latency and stall stability
    initial begin
        bit          prev_stall;
        logic [23:0] pd;
        logic        pl;
        exp_t        e;
        int          a;
        prev_stall = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                acc_q.delete();
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'({out_last, out_data}), 32'({pl, pd}));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_run++; n_fail++;
                        $display("FAIL unexpected_out: got %h, expected no output", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_last", 32'(out_last), 32'(e.last));
                    end
                    if (acc_q.size() != 0) begin
                        a = acc_q.pop_front();
                        if (lat_chk) check("latency", 32'(cyc - a), 32'd3);
                    end
                end
                if (in_valid && in_ready) acc_q.push_back(cyc);
                prev_stall = out_valid && !out_ready;
                pd = out_data;
                pl = out_last;
            end
        end
    end

    initial begin
        logic [7:0] br, bg, bb;

        // gray frame
        tbl[0]  = '{8'hFF, 8'hFF, 8'hFF, 2'd0, 24'hFFFFFF, 1'b0};
        tbl[1]  = '{8'h00, 8'h00, 8'h00, 2'd0, 24'h000000, 1'b0};
        tbl[2]  = '{8'hFF, 8'h00, 8'h00, 2'd0, 24'h4D4D4D, 1'b0};
        tbl[3]  = '{8'h64, 8'h32, 8'hC8, 2'd0, 24'h525252, 1'b1};
        // YCbCr frame; later mode fields must be ignored
        tbl[4]  = '{8'hFF, 8'h00, 8'h00, 2'd1, 24'h4D55FF, 1'b0};
        tbl[5]  = '{8'hFF, 8'hFF, 8'hFF, 2'd0, 24'hFF8080, 1'b0};
        tbl[6]  = '{8'h00, 8'hFF, 8'h00, 2'd2, 24'h952B15, 1'b0};
        tbl[7]  = '{8'h00, 8'h00, 8'hFF, 2'd0, 24'h1DFF6B, 1'b1};
        // bypass frame
        tbl[8]  = '{8'h12, 8'h34, 8'h56, 2'd2, 24'h123456, 1'b0};
        tbl[9]  = '{8'h01, 8'h02, 8'h03, 2'd2, 24'h010203, 1'b0};
        tbl[10] = '{8'hFF, 8'h00, 8'h80, 2'd2, 24'hFF0080, 1'b0};
        tbl[11] = '{8'h7F, 8'h80, 8'h81, 2'd2, 24'h7F8081, 1'b1};
        // reserved mode behaves as bypass
        tbl[12] = '{8'hAB, 8'hCD, 8'hEF, 2'd3, 24'hABCDEF, 1'b0};
        tbl[13] = '{8'h00, 8'h00, 8'h00, 2'd0, 24'h000000, 1'b0};
        tbl[14] = '{8'hFF, 8'hFF, 8'hFF, 2'd1, 24'hFFFFFF, 1'b0};
        tbl[15] = '{8'h01, 8'h80, 8'hFE, 2'd0, 24'h0180FE, 1'b1};

        // mode switches 0 -> 2 after second pixel; applies from next frame
        wrap[0] = '{8'h0A, 8'h14, 8'h1E, 2'd0, 24'h121212, 1'b0};
        wrap[1] = '{8'hC8, 8'h64, 8'h32, 2'd0, 24'h7C7C7C, 1'b0};
        wrap[2] = '{8'h00, 8'hFF, 8'h00, 2'd2, 24'h959595, 1'b0};
        wrap[3] = '{8'hFF, 8'h00, 8'h00, 2'd2, 24'h4D4D4D, 1'b1};
        wrap[4] = '{8'h0A, 8'h14, 8'h1E, 2'd2, 24'h0A141E, 1'b0};
        wrap[5] = '{8'hC8, 8'h64, 8'h32, 2'd2, 24'hC86432, 1'b0};
        wrap[6] = '{8'h00, 8'hFF, 8'h00, 2'd2, 24'h00FF00, 1'b0};
        wrap[7] = '{8'hFF, 8'h00, 8'h00, 2'd2, 24'hFF0000, 1'b1};

        // reset / idle
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_out_data", 32'(out_data), 32'd0);
        check("idle_pix_cnt", 32'(pix_cnt), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // table vectors, back-to-back, latency checked
        lat_chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back('{tbl[i].data, tbl[i].last});
            send(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].mode, i % 4);
        end
        drain();

        // frame wrap with mid-frame mode change
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{wrap[i].data, wrap[i].last});
            send(wrap[i].r, wrap[i].g, wrap[i].b, wrap[i].mode, i % 4);
        end
        drain();
        @(negedge clk);
        check("wrap_cnt_end", 32'(pix_cnt), 32'd0);
        @(posedge clk); #1;

        // backpressure, bypass stream of 10 pixels
        lat_chk = 1'b0;
        bp_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            br = 8'(i * 20 + 1);
            bg = 8'(i * 7 + 3);
            bb = 8'(255 - i * 13);
            exp_q.push_back('{{br, bg, bb}, (i % 4) == 3});
            send(br, bg, bb, 2'd2, i % 4);
        end
        drain();
        bp_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // mid-stream reset with three pixels in flight (nothing expected out)
        send(8'h11, 8'h22, 8'h33, 2'd2, 2);
        send(8'h44, 8'h55, 8'h66, 2'd2, 3);
        send(8'h77, 8'h88, 8'h99, 2'd2, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_data", 32'(out_data), 32'd0);
        check("mrst_out_last", 32'(out_last), 32'd0);
        check("mrst_pix_cnt", 32'(pix_cnt), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // clean gray frame after reset
        lat_chk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{tbl[i].data, tbl[i].last});
            send(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].mode, i);
        end
        drain();
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
